// File: rtl/gfx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// gfx_mem_arbiter
//
// Shares the DDR2 address FIFO (af) and write-data FIFO (wdf) between the
// graphics write clients (0 = line engine, 1 = frame filler, 2 = cache bypass)
// and the pixel feeder's read requests. The RequestController downstream only
// ever sees a single graphics master.
//
// A write is atomic: one af write command together with wdf beat0, followed
// by wdf beat1. No other client can push in between. Reads take priority,
// but only RD_MAX reads in a row are granted while a writer is waiting.
// Writers are served round-robin.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_req[N_WR]               writer requests, held until wr_done
//   wr_addr[31*N_WR]           writer addresses, slice i = [31*i +: 31]
//   wr_data[128*N_WR]          current beat data per writer (beat0, then beat1)
//   wr_mask[16*N_WR]           current beat mask per writer
//   wr_beat_ack[N_WR]          pulse: that writer's beat0 (and af cmd) pushed
//   wr_done[N_WR]              pulse: that writer's beat1 pushed
//   rd_req, rd_addr            pixel-feeder read request and address
//   rd_ack                     pulse: read command pushed into af
//   af_full, wdf_full          FIFO backpressure
//   af_cmd_din/addr_din/wr_en  af push port (cmd 000 = write, 001 = read)
//   wdf_din/mask_din/wr_en     wdf push port
//   grant_id                   current owner (N_WR means the reader)
//   busy                       high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module gfx_mem_arbiter #(
  parameter int N_WR   = 3,
  parameter int RD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_WR-1:0]     wr_req,
  input  logic [31*N_WR-1:0]  wr_addr,
  input  logic [128*N_WR-1:0] wr_data,
  input  logic [16*N_WR-1:0]  wr_mask,
  output logic [N_WR-1:0]     wr_beat_ack,
  output logic [N_WR-1:0]     wr_done,
  input  logic                rd_req,
  input  logic [30:0]         rd_addr,
  output logic                rd_ack,
  input  logic                af_full,
  input  logic                wdf_full,
  output logic [2:0]          af_cmd_din,
  output logic [30:0]         af_addr_din,
  output logic                af_wr_en,
  output logic [127:0]        wdf_din,
  output logic [15:0]         wdf_mask_din,
  output logic                wdf_wr_en,
  output logic [1:0]          grant_id,
  output logic                busy
);

  localparam int CW = $clog2(RD_MAX + 1);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD, WR_BEAT1} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      grant_reg, grant_next;
  logic [1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]   rd_cnt_reg, rd_cnt_next;

  logic            any_wr;
  logic [1:0]      win_idx;
  logic [1:0]      sel;
  logic            beat0_push;
  logic            beat1_push;

  logic [1:0]      cand_idx [N_WR];
  logic [N_WR-1:0] cand_req;
  logic [30:0]     addr_arr [N_WR];
  logic [127:0]    data_arr [N_WR];
  logic [15:0]     mask_arr [N_WR];

  assign any_wr = |wr_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_WR; gi++) begin : g_client
      // Candidate gi is the client gi places after rr_ptr, wrapped to N_WR.
      // rr_ptr is always below N_WR, so one conditional subtract suffices.
      logic [2:0] cand_sum;
      assign cand_sum      = {1'b0, rr_ptr_reg} + 3'(gi);
      assign cand_idx[gi]  = (cand_sum >= 3'(N_WR)) ? 2'(cand_sum - 3'(N_WR)) : cand_sum[1:0];
      assign cand_req[gi]  = wr_req[cand_idx[gi]];

      assign addr_arr[gi]  = wr_addr[31*gi +: 31];
      assign data_arr[gi]  = wr_data[128*gi +: 128];
      assign mask_arr[gi]  = wr_mask[16*gi +: 16];

      assign wr_beat_ack[gi] = beat0_push && (grant_reg == 2'(gi));
      assign wr_done[gi]     = beat1_push && (grant_reg == 2'(gi));
    end
  endgenerate

  // First requesting candidate in rotated order wins.
  always_comb begin
    win_idx = cand_idx[0];
    for (int k = N_WR - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  // grant_reg holds N_WR while a read is in flight; clamp so the writer
  // slice mux always sees a legal index (outputs are gated by state anyway).
  assign sel = (grant_reg < 2'(N_WR)) ? grant_reg : 2'd0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      rd_cnt_reg <= rd_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    rd_cnt_next = rd_cnt_reg;
    case (state_reg)
      IDLE: begin
        // The read wins unless it has used up its run while a writer waits.
        if (rd_req && ((rd_cnt_reg < CW'(RD_MAX)) || !any_wr)) begin
          state_next = RD_CMD;
          grant_next = 2'(N_WR);
        end else if (any_wr) begin
          state_next = WR_CMD;
          grant_next = win_idx;
        end
      end
      RD_CMD: begin
        if (!af_full) begin
          state_next = IDLE;
          // Count only reads that actually delayed a writer.
          if (any_wr) begin
            if (rd_cnt_reg != CW'(RD_MAX)) begin
              rd_cnt_next = rd_cnt_reg + 1'b1;
            end
          end else begin
            rd_cnt_next = '0;
          end
        end
      end
      WR_CMD: begin
        if (!af_full && !wdf_full) begin
          state_next = WR_BEAT1;
        end
      end
      WR_BEAT1: begin
        if (!wdf_full) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_reg == 2'(N_WR - 1)) ? 2'd0 : grant_reg + 1'b1;
          rd_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: strobes depend on state and full flags only, so a push
  // never happens in a cycle where the target FIFO reports full.
  always_comb begin
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    rd_ack       = 1'b0;
    beat0_push   = 1'b0;
    beat1_push   = 1'b0;
    af_cmd_din   = '0;
    af_addr_din  = '0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    case (state_reg)
      RD_CMD: begin
        af_cmd_din  = CMD_READ;
        af_addr_din = rd_addr;
        if (!af_full) begin
          af_wr_en = 1'b1;
          rd_ack   = 1'b1;
        end
      end
      WR_CMD: begin
        af_cmd_din   = CMD_WRITE;
        af_addr_din  = addr_arr[sel];
        wdf_din      = data_arr[sel];
        wdf_mask_din = mask_arr[sel];
        // Command and beat0 go together so the pair can never be split.
        if (!af_full && !wdf_full) begin
          af_wr_en   = 1'b1;
          wdf_wr_en  = 1'b1;
          beat0_push = 1'b1;
        end
      end
      WR_BEAT1: begin
        wdf_din      = data_arr[sel];
        wdf_mask_din = mask_arr[sel];
        if (!wdf_full) begin
          wdf_wr_en  = 1'b1;
          beat1_push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: doc/gfx_mem_arbiter.md
# gfx_mem_arbiter

Shares the single DDR2 address FIFO (af) and write-data FIFO (wdf) command port between the checkpoint-3 graphics writers (line engine, frame filler, cache bypass) and the pixel feeder's read requests. Write transactions are atomic: one af write command plus two 128-bit wdf beats, never interleaved with another client. The block sits between the graphics engines and the RequestController's graphics inputs, so the RequestController sees only one graphics master.

## Interface
- N_WR, 3: number of write clients (index 0 = line, 1 = filler, 2 = bypass)
- RD_MAX, 4: maximum consecutive read grants while any writer is pending
- clk  in  1  CPU clock (cpu_clk_g domain)
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  N_WR  per-writer request; held high until the matching wr_done
- wr_addr  in  31*N_WR  per-writer DDR2 address, slice i = [31*i+30:31*i]; stable while wr_req is high
- wr_data  in  128*N_WR  current beat data; beat0 until wr_beat_ack, then beat1
- wr_mask  in  16*N_WR  current beat mask; same beat sequencing as wr_data
- wr_beat_ack  out  N_WR  one-cycle pulse when that client's beat0 is written
- wr_done  out  N_WR  one-cycle pulse when that client's beat1 is written
- rd_req  in  1  pixel-feeder read request; held until rd_ack
- rd_addr  in  31  read address
- rd_ack  out  1  one-cycle pulse when the read command enters af
- af_full, wdf_full  in  1 each  FIFO backpressure
- af_cmd_din  out  3  000 = write, 001 = read
- af_addr_din  out  31  command address
- af_wr_en  out  1  af push
- wdf_din  out  128  write data
- wdf_mask_din  out  16  write mask
- wdf_wr_en  out  1  wdf push
- grant_id  out  2  registered index of the current owner (N_WR = reader)
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, RD_CMD, WR_CMD, WR_BEAT1.
- **Arbitration in IDLE (registered):**
  - If rd_req is high and rd_cnt < RD_MAX, go to RD_CMD.
  - Otherwise, if any wr_req is high, go to WR_CMD. The winner is the lowest index at or after rr_ptr, with wrap-around.
  - If rd_req is high and no writer is pending, the read wins regardless of rd_cnt.
- **RD_CMD:**
  - While af_full = 0: af_wr_en = 1, cmd 001, addr = rd_addr, rd_ack = 1, then go to IDLE.
  - rd_cnt increments if any wr_req is high at that cycle; otherwise it clears.
- **WR_CMD:**
  - While af_full = 0 and wdf_full = 0: af_wr_en = 1 and wdf_wr_en = 1 in the same cycle.
  - cmd 000, addr = winner's wr_addr, data/mask = winner's slice.
  - wr_beat_ack[winner] = 1, then go to WR_BEAT1.
  - If either FIFO is full, stall with no pushes.
- **WR_BEAT1:**
  - While wdf_full = 0: wdf_wr_en = 1 with the winner's slice.
  - wr_done[winner] = 1, rr_ptr <= (winner + 1) mod N_WR, rd_cnt <= 0, then go to IDLE.
- Push strobes and ack/done pulses are combinational from state, grant and full flags. Data and address outputs are muxed from grant_id and are don't-care when the strobes are low.
- A withdrawn request mid-transaction is illegal. The block ignores it and completes the transaction anyway.
- rr_ptr is 2 bits and wraps modulo N_WR. rd_cnt is saturating, clog2(RD_MAX+1) bits.

## Timing
- **Reset (any time, including mid-transaction):**
  - State goes to IDLE; rr_ptr = 0, rd_cnt = 0, grant_id = 0, busy = 0.
  - All strobes and pulses go to 0; af_cmd_din, af_addr_din, wdf_din and wdf_mask_din read 0.
  - Partial bursts are not completed.
- **Write latency** (request sampled in IDLE at cycle T, no backpressure): af + beat0 at T+1, beat1 + wr_done at T+2, IDLE at T+3. A new grant is possible at T+3.
- **Read latency:** rd_ack at T+1, IDLE at T+2.
- af_wr_en is never asserted while af_full = 1, and wdf_wr_en is never asserted while wdf_full = 1.
- Between a WR_CMD push and its beat1, no other client's af or wdf push occurs.
- When rd_req and wr_req rise in the same cycle, the read wins unless rd_cnt = RD_MAX.

## Test plan
- **Single write:** client 1 requests at 0x0000100, beat0 = 0xAA..AA, beat1 = 0x55..55, mask 0.
  - Expected: af push {000, 0x0000100} with wdf 0xAA..AA at T+1, then wdf 0x55..55 at T+2.
  - Expected: wr_beat_ack[1] at T+1, wr_done[1] at T+2.
- **Round-robin:** all three writers hold req continuously.
  - Expected grant order 0, 1, 2, 0, 1, 2.
  - Expected: 6 transactions complete in 18 cycles.
- **Read priority and starvation limit:** rd_req held high with writer 2 pending, RD_MAX = 4.
  - Expected: exactly 4 rd_ack pulses, then one writer-2 transaction, then reads resume.
- **Backpressure:**
  - Case 1: wdf_full high for 5 cycles at WR_BEAT1. Expected: no pushes and state held; beat1 pushes on the first cycle wdf_full = 0.
  - Case 2: af_full high in WR_CMD. Expected: neither af nor wdf pushes.
- **Reset mid-burst:** assert rst_n = 0 in WR_BEAT1.
  - Expected: all outputs 0 immediately; no beat1 push; after release, the first grant goes to client 0.
- **Simultaneous request:** rd_req and wr_req[0] rise in the same cycle with rd_cnt = 0.
  - Expected: rd_ack first, then writer 0 granted on the next IDLE.
